// File: rtl/bcd_ascii_streamer.sv
// Streams one captured packed-BCD reading as an ASCII frame: digits (MSD first),
// unit character, CR, LF -- one byte per valid/ready handshake.
module bcd_ascii_streamer #(
  parameter int unsigned DIGITS_P    = 4,
  parameter logic [7:0]  UNIT_TEMP_P = 8'h43,
  parameter logic [7:0]  UNIT_LDR_P  = 8'h4C,
  parameter logic [7:0]  BAD_DIGIT_P = 8'h3F
) (
  input  logic                    Clk_i,
  input  logic                    Reset_i,
  input  logic                    Data_Available_i,
  input  logic [4*DIGITS_P-1:0]   Data_i,
  input  logic [1:0]              Div_Stages_i,
  input  logic                    Temp_LDR_i,
  input  logic                    Tx_Ready_i,
  output logic                    Tx_Valid_o,
  output logic [7:0]              Tx_Data_o,
  output logic                    Busy_o,
  output logic                    Overrun_o,
  output logic                    Digit_Error_o
);

  localparam int unsigned DATA_W = 4 * DIGITS_P;
  localparam logic [7:0]  CR_CHAR = 8'h0D;
  localparam logic [7:0]  LF_CHAR = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIGIT,
    ST_UNIT,
    ST_CR,
    ST_LF
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        stages_q;
  logic              sel_q;
  logic [1:0]        idx;

  logic              transfer;
  logic              capture;
  logic [3:0]        cur_nib;
  logic [3:0]        nxt_nib;
  logic [1:0]        nxt_idx;

  function automatic logic [7:0] ascii_digit(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : BAD_DIGIT_P;
  endfunction

  // Handshake and capture qualification; a strobe on the LF transfer edge starts the next frame.
  assign transfer = Tx_Valid_o & Tx_Ready_i;
  assign capture  = Data_Available_i &
                    ((state == ST_IDLE) || ((state == ST_LF) && transfer));
  assign nxt_idx  = idx + 2'd1;
  assign cur_nib  = data_q[{idx, 2'b00} +: 4];
  assign nxt_nib  = data_q[{nxt_idx, 2'b00} +: 4];

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state         <= ST_IDLE;
      data_q        <= '0;
      stages_q      <= 2'd0;
      sel_q         <= 1'b0;
      idx           <= 2'd0;
      Tx_Valid_o    <= 1'b0;
      Tx_Data_o     <= 8'h00;
      Busy_o        <= 1'b0;
      Overrun_o     <= 1'b0;
      Digit_Error_o <= 1'b0;
    end else begin
      Overrun_o <= Data_Available_i & ~capture & (state != ST_IDLE);
      if (capture) begin
        state         <= ST_DIGIT;
        data_q        <= Data_i;
        stages_q      <= Div_Stages_i;
        sel_q         <= Temp_LDR_i;
        idx           <= 2'd0;
        Digit_Error_o <= 1'b0;
        Tx_Valid_o    <= 1'b1;
        Busy_o        <= 1'b1;
        Tx_Data_o     <= ascii_digit(Data_i[3:0]);
      end else begin
        case (state)
          ST_DIGIT: begin
            if (transfer) begin
              if (cur_nib > 4'd9) Digit_Error_o <= 1'b1;
              if (idx == stages_q) begin
                state     <= ST_UNIT;
                Tx_Data_o <= sel_q ? UNIT_TEMP_P : UNIT_LDR_P;
              end else begin
                idx       <= nxt_idx;
                Tx_Data_o <= ascii_digit(nxt_nib);
              end
            end
          end
          ST_UNIT: begin
            if (transfer) begin
              state     <= ST_CR;
              Tx_Data_o <= CR_CHAR;
            end
          end
          ST_CR: begin
            if (transfer) begin
              state     <= ST_LF;
              Tx_Data_o <= LF_CHAR;
            end
          end
          ST_LF: begin
            if (transfer) begin
              state      <= ST_IDLE;
              Tx_Valid_o <= 1'b0;
              Busy_o     <= 1'b0;
              Tx_Data_o  <= 8'h00;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_ascii_streamer.sv
// Scoreboard bench: a frame-level model predicts every byte and flag of bcd_ascii_streamer.
module tb_bcd_ascii_streamer;

  logic        Clk_i = 1'b0;
  logic        Reset_i = 1'b1;
  logic        Data_Available_i = 1'b0;
  logic [15:0] Data_i = 16'h0000;
  logic [1:0]  Div_Stages_i = 2'd0;
  logic        Temp_LDR_i = 1'b0;
  logic        Tx_Ready_i = 1'b0;
  logic        Tx_Valid_o;
  logic [7:0]  Tx_Data_o;
  logic        Busy_o;
  logic        Overrun_o;
  logic        Digit_Error_o;

  bcd_ascii_streamer dut (
    .Clk_i            (Clk_i),
    .Reset_i          (Reset_i),
    .Data_Available_i (Data_Available_i),
    .Data_i           (Data_i),
    .Div_Stages_i     (Div_Stages_i),
    .Temp_LDR_i       (Temp_LDR_i),
    .Tx_Ready_i       (Tx_Ready_i),
    .Tx_Valid_o       (Tx_Valid_o),
    .Tx_Data_o        (Tx_Data_o),
    .Busy_o           (Busy_o),
    .Overrun_o        (Overrun_o),
    .Digit_Error_o    (Digit_Error_o)
  );

  always #5 Clk_i = ~Clk_i;

  int checks = 0;
  int passed = 0;

  logic [7:0] mq[$];     // model: bytes of the current frame still to transfer
  logic [7:0] exp_q[$];  // scoreboard: expected bytes, popped by the monitor
  logic       exp_err = 1'b0;
  logic       exp_ovr = 1'b0;
  logic       exp_rst = 1'b1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
  endtask

  // Frame contents straight from the rules: digit chars MSD first, unit, CR, LF.
  task automatic push_frame(input logic [15:0] d, input logic [1:0] st, input logic tl);
    logic [7:0] b;
    int nib;
    for (int k = 0; k <= int'(st); k++) begin
      nib = int'((d >> (4 * k)) & 16'hF);
      b = (nib <= 9) ? 8'(48 + nib) : 8'h3F;
      mq.push_back(b);
      exp_q.push_back(b);
    end
    b = tl ? 8'h43 : 8'h4C;
    mq.push_back(b);     exp_q.push_back(b);
    mq.push_back(8'h0D); exp_q.push_back(8'h0D);
    mq.push_back(8'h0A); exp_q.push_back(8'h0A);
  endtask

  // Apply inputs for one clock, then advance the model at that edge.
  task automatic cyc(input logic stb, input logic [15:0] d, input logic [1:0] st,
                     input logic tl, input logic rdy, input logic rst);
    logic [7:0] b;
    Data_Available_i = stb;
    Data_i           = d;
    Div_Stages_i     = st;
    Temp_LDR_i       = tl;
    Tx_Ready_i       = rdy;
    Reset_i          = rst;
    @(posedge Clk_i);
    if (rst) begin
      mq.delete();
      exp_q.delete();
      exp_err = 1'b0;
      exp_ovr = 1'b0;
      exp_rst = 1'b1;
    end else begin
      exp_rst = 1'b0;
      exp_ovr = 1'b0;
      if (mq.size() > 0 && rdy) begin
        b = mq.pop_front();
        if (b == 8'h3F) exp_err = 1'b1;
      end
      if (stb) begin
        if (mq.size() == 0) begin
          push_frame(d, st, tl);
          exp_err = 1'b0;
        end else begin
          exp_ovr = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 2'd0, 1'b0, rdy, 1'b0);
  endtask

  // Monitor: sample between edges, pop the scoreboard on every handshake.
  initial begin
    logic       hold = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] want;
    forever begin
      @(negedge Clk_i);
      check("valid", 8'(Tx_Valid_o), 8'(mq.size() > 0));
      check("busy", 8'(Busy_o), 8'(mq.size() > 0));
      check("overrun", 8'(Overrun_o), 8'(exp_ovr));
      check("digit_error", 8'(Digit_Error_o), 8'(exp_err));
      if (exp_rst) check("reset_data", Tx_Data_o, 8'h00);
      else if (hold) check("stable_data", Tx_Data_o, held);
      if (Tx_Valid_o && Tx_Ready_i && !Reset_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte: got %02h expected none at %0t", Tx_Data_o, $time);
        end else begin
          want = exp_q.pop_front();
          check("byte", Tx_Data_o, want);
        end
      end
      hold = Tx_Valid_o && !Tx_Ready_i && !Reset_i;
      held = Tx_Data_o;
    end
  end

  initial begin
    cyc(1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // two-digit temperature frame, ready held high
    cyc(1'b1, 16'h0052, 2'd1, 1'b1, 1'b1, 1'b0);
    idle(7, 1'b1);

    // four-digit LDR frame with ready toggling
    cyc(1'b1, 16'h1234, 2'd3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 16'h0000, 2'd0, 1'b0, 1'(i % 2), 1'b0);
    idle(2, 1'b1);

    // bad nibble, then a clean capture clears the error
    cyc(1'b1, 16'h00A7, 2'd1, 1'b1, 1'b1, 1'b0);
    idle(7, 1'b1);
    cyc(1'b1, 16'h0009, 2'd0, 1'b0, 1'b1, 1'b0);
    idle(6, 1'b1);

    // second strobe mid-frame is dropped
    cyc(1'b1, 16'h0052, 2'd1, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);
    cyc(1'b1, 16'h9876, 2'd3, 1'b0, 1'b1, 1'b0);
    idle(8, 1'b1);

    // strobe on the LF transfer edge chains frames without a gap
    cyc(1'b1, 16'h0003, 2'd0, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);
    cyc(1'b1, 16'h0456, 2'd2, 1'b0, 1'b1, 1'b0);
    idle(8, 1'b1);

    // reset while a byte is stalled, then a clean frame
    cyc(1'b1, 16'h4321, 2'd3, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);
    cyc(1'b1, 16'h8765, 2'd3, 1'b1, 1'b1, 1'b0);
    idle(9, 1'b1);

    // randomized traffic, including bad nibbles and occasional resets
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 4) == 0), 16'($urandom()), 2'($urandom()),
          1'($urandom()), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 120) == 0));
    end

    // drain with a bounded budget
    for (int i = 0; i < 20 && mq.size() > 0; i++) idle(1, 1'b1);
    idle(2, 1'b1);
    check("scoreboard_empty", 8'(exp_q.size()), 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bcd_ascii_streamer.md
# bcd_ascii_streamer

Consumer of the sensor data converter's packed-BCD result. Captures one converted reading (up to four BCD digits plus digit count and sensor select), then streams it as an ASCII frame, one byte per valid/ready handshake, to the UART transmit path. Frame = digits (most significant first), unit character, CR, LF.

## Interface
- DIGITS_P, 4, maximum BCD digits per reading; Data_i width is 4*DIGITS_P.
- UNIT_TEMP_P, 8'h43 ('C'), unit character sent when Temp_LDR_i = 1.
- UNIT_LDR_P, 8'h4C ('L'), unit character sent when Temp_LDR_i = 0.
- BAD_DIGIT_P, 8'h3F ('?'), character substituted for a nibble > 9.

- Clk_i  in  1  single system clock, all logic on rising edge.
- Reset_i  in  1  synchronous, active-high reset.
- Data_Available_i  in  1  one-cycle strobe; Data_i, Div_Stages_i and Temp_LDR_i are valid in this cycle.
- Data_i  in  16  packed BCD; nibble k = Data_i[4k+3:4k]; nibble 0 is the most significant digit.
- Div_Stages_i  in  2  number of digits minus 1 (0..3).
- Temp_LDR_i  in  1  1 = temperature reading, 0 = LDR reading.
- Tx_Ready_i  in  1  downstream can accept a byte this cycle.
- Tx_Valid_o  out  1  Tx_Data_o holds a byte to transfer.
- Tx_Data_o  out  8  ASCII byte.
- Busy_o  out  1  a frame is captured and not yet fully transferred.
- Overrun_o  out  1  one-cycle pulse when a strobe is dropped.
- Digit_Error_o  out  1  sticky; set when any nibble > 9 was sent; cleared by reset or by the next accepted capture.

## Operation
- Transfer occurs on any rising edge where Tx_Valid_o = 1 and Tx_Ready_i = 1. While Tx_Valid_o = 1 and Tx_Ready_i = 0, Tx_Data_o stays stable and Tx_Valid_o stays high. Tx_Valid_o never drops without a transfer, except on reset.
- States: IDLE, DIGIT, UNIT, CR, LF.
- IDLE: on Data_Available_i, register Data_i, Div_Stages_i and Temp_LDR_i. Clear digit index and Digit_Error_o. Go to DIGIT.
- DIGIT: Tx_Data_o = 8'h30 + nibble[index] if nibble ≤ 9, else BAD_DIGIT_P (and set Digit_Error_o on that transfer). On transfer: if index = stored Div_Stages, go to UNIT; else index + 1.
- UNIT: Tx_Data_o = UNIT_TEMP_P or UNIT_LDR_P from the stored select. On transfer, go to CR.
- CR: 8'h0D. On transfer, go to LF.
- LF: 8'h0A. On transfer, go to IDLE.
  - If Data_Available_i is high in that same cycle, capture it and go directly to DIGIT (zero-gap frames).
- Strobe while Busy_o = 1 (other than the LF-transfer cycle): ignore it, pulse Overrun_o the next cycle, and leave the current frame unaffected.
- Nibbles above the stored Div_Stages are never sent.
- Frame length = Div_Stages + 4 bytes (4..7).

## Timing
- Reset values: Tx_Valid_o = 0, Tx_Data_o = 8'h00, Busy_o = 0, Overrun_o = 0, Digit_Error_o = 0, state = IDLE.
- Reset asserted mid-frame: all outputs return to reset values at the next edge and the frame is abandoned.
- Strobe sampled at edge n gives Tx_Valid_o = 1 and Busy_o = 1 from n (registered) with the first digit. That is 1-cycle latency from strobe to first valid byte.
- With Tx_Ready_i held high, one byte transfers per cycle. A full 4-digit frame occupies 7 consecutive cycles.
- Busy_o falls at the edge that completes the LF transfer, unless a same-cycle strobe is captured.
- Tx_Data_o is registered; no combinational path exists from Tx_Ready_i to Tx_Data_o or Tx_Valid_o.

## Test plan
- Data_i = 16'h0052 (nibble0 = 2, nibble1 = 5), Div_Stages_i = 1, Temp_LDR_i = 1, Tx_Ready_i = 1 -> bytes 32,35,43,0D,0A on 5 consecutive cycles; Busy_o then low.
- Data_i = 16'h1234, Div_Stages_i = 3, Temp_LDR_i = 0, Tx_Ready_i toggling 1/0 -> bytes 34,33,32,31,4C,0D,0A; Tx_Data_o stable during every ready-low cycle.
- Data_i = 16'h00A7, Div_Stages_i = 1 -> bytes 37,3F,...; Digit_Error_o = 1 after the '?' transfer and cleared on the next capture.
- Second strobe during the third byte of a frame -> Overrun_o pulses 1 cycle; the first frame completes unchanged; no second frame is sent.
- Second strobe in the LF-transfer cycle -> next cycle shows Tx_Valid_o = 1 with the new first digit; Busy_o never drops.
- Reset_i asserted with Tx_Valid_o = 1 and Tx_Ready_i = 0 -> next cycle all outputs are 0; a subsequent strobe produces a clean full frame.
